// File: rtl/jogador_automatico.sv
// Automatic player: watches the game's LED display, captures each shown
// element, and once the display goes quiet replays the captured sequence
// on the button outputs. Ends on game won/lost/timeout or on a bad capture.
module jogador_automatico #(
    parameter int HOLD      = 10,
    parameter int GAP       = 10,
    parameter int QUIET     = 100,
    parameter int JOGAR_CYC = 5
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic [3:0] leds,
    input  logic       ganhou,
    input  logic       perdeu,
    input  logic       timeout,
    output logic       jogar,
    output logic [3:0] botoes,
    output logic       ocupado,
    output logic       fim,
    output logic       erro_captura,
    output logic [4:0] db_tamanho,
    output logic [3:0] db_estado
);

    localparam int CNT_MAX = (HOLD > GAP) ? ((HOLD > JOGAR_CYC) ? HOLD : JOGAR_CYC)
                                          : ((GAP > JOGAR_CYC) ? GAP : JOGAR_CYC);
    localparam int CW = $clog2(CNT_MAX + 1);
    localparam int QW = $clog2(QUIET + 1);

    localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD - 1);
    localparam logic [CW-1:0] GAP_LAST   = CW'(GAP - 1);
    localparam logic [CW-1:0] JOGAR_LAST = CW'(JOGAR_CYC - 1);
    localparam logic [QW-1:0] QUIET_VAL  = QW'(QUIET);

    typedef enum logic [3:0] {
        INICIAL     = 4'd0,
        PULSA_JOGAR = 4'd1,
        ESCUTA      = 4'd2,
        ACESO       = 4'd3,
        PRESSIONA   = 4'd4,
        SOLTA       = 4'd5,
        FIM         = 4'd15
    } estado_t;

    estado_t       r_estado, w_next;
    logic [CW-1:0] r_cnt, w_cnt_next;
    logic [QW-1:0] r_quiet, w_quiet_next, w_quiet_inc;
    logic [4:0]    r_index, w_index_next, w_index_inc;
    logic [4:0]    r_tamanho, w_tamanho_next;
    logic          r_erro, w_erro_next;
    logic          w_wr_en;
    logic          w_onehot;
    logic          w_end;
    logic          w_ativo;
    logic [3:0]    w_botoes_next;
    logic [3:0]    r_mem [16];

    logic          r_jogar, r_ocupado, r_fim;
    logic [3:0]    r_botoes, r_db_estado;

    assign w_onehot    = (leds == 4'b0001) || (leds == 4'b0010) ||
                         (leds == 4'b0100) || (leds == 4'b1000);
    assign w_end       = ganhou || perdeu || timeout;
    assign w_ativo     = (r_estado != INICIAL) && (r_estado != FIM);
    assign w_quiet_inc = (r_quiet == QUIET_VAL) ? r_quiet : r_quiet + 1'b1;
    assign w_index_inc = r_index + 5'd1;

    // Next-state and next-register computation for the capture/replay FSM.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned, which would infer a latch.
        w_next         = r_estado;
        w_cnt_next     = r_cnt;
        w_quiet_next   = r_quiet;
        w_index_next   = r_index;
        w_tamanho_next = r_tamanho;
        w_erro_next    = r_erro;
        w_wr_en        = 1'b0;

        case (r_estado)
            INICIAL, FIM: begin
                if (iniciar) begin
                    w_next         = PULSA_JOGAR;
                    w_cnt_next     = '0;
                    w_quiet_next   = '0;
                    w_index_next   = '0;
                    w_tamanho_next = '0;
                    w_erro_next    = 1'b0;
                end
            end
            PULSA_JOGAR: begin
                if (r_cnt == JOGAR_LAST) begin
                    w_next       = ESCUTA;
                    w_cnt_next   = '0;
                    w_quiet_next = '0;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            ESCUTA: begin
                if (leds == 4'b0000) begin
                    w_quiet_next = w_quiet_inc;
                    if ((w_quiet_inc == QUIET_VAL) && (r_tamanho != 5'd0)) begin
                        w_next       = PRESSIONA;
                        w_index_next = '0;
                        w_cnt_next   = '0;
                    end
                end else if (!w_onehot || (r_tamanho == 5'd16)) begin
                    w_erro_next = 1'b1;
                    w_next      = FIM;
                end else begin
                    w_wr_en        = 1'b1;
                    w_tamanho_next = r_tamanho + 5'd1;
                    w_quiet_next   = '0;
                    w_next         = ACESO;
                end
            end
            ACESO: begin
                if (leds == 4'b0000) begin
                    w_next       = ESCUTA;
                    w_quiet_next = '0;
                end
            end
            PRESSIONA: begin
                if (r_cnt == HOLD_LAST) begin
                    w_next     = SOLTA;
                    w_cnt_next = '0;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            SOLTA: begin
                if (r_cnt == GAP_LAST) begin
                    w_cnt_next   = '0;
                    w_index_next = w_index_inc;
                    if (w_index_inc == r_tamanho) begin
                        w_next         = ESCUTA;
                        w_tamanho_next = '0;
                        w_quiet_next   = '0;
                    end else begin
                        w_next = PRESSIONA;
                    end
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            default: w_next = INICIAL;
        endcase

        // Game end overrides whatever transition the current state chose.
        if (w_ativo && w_end) begin
            w_next = FIM;
        end
    end

    // Button drive for the coming cycle; only PRESSIONA shows a stored element.
    always_comb begin
        w_botoes_next = 4'b0000;
        if (w_next == PRESSIONA) begin
            w_botoes_next = r_mem[w_index_next[3:0]];
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_estado    <= INICIAL;
            r_cnt       <= '0;
            r_quiet     <= '0;
            r_index     <= '0;
            r_tamanho   <= '0;
            r_erro      <= 1'b0;
            r_jogar     <= 1'b0;
            r_botoes    <= 4'b0000;
            r_ocupado   <= 1'b0;
            r_fim       <= 1'b0;
            r_db_estado <= 4'd0;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
            r_estado    <= w_next;
            r_cnt       <= w_cnt_next;
            r_quiet     <= w_quiet_next;
            r_index     <= w_index_next;
            r_tamanho   <= w_tamanho_next;
            r_erro      <= w_erro_next;
            r_jogar     <= (w_next == PULSA_JOGAR);
            r_botoes    <= w_botoes_next;
            r_ocupado   <= (w_next != INICIAL) && (w_next != FIM);
            r_fim       <= (w_next == FIM);
            r_db_estado <= w_next;
        end
    end

    // Capture memory write; index is below 16 whenever a write is enabled.
    always_ff @(posedge clock) begin
        // NOTE: the memory has no reset; entries are always written before they are replayed.
        if (w_wr_en) begin
            r_mem[r_tamanho[3:0]] <= leds;
        end
    end

    assign jogar        = r_jogar;
    assign botoes       = r_botoes;
    assign ocupado      = r_ocupado;
    assign fim          = r_fim;
    assign erro_captura = r_erro;
    assign db_tamanho   = r_tamanho;
    assign db_estado    = r_db_estado;

endmodule

// File: tb/tb_jogador_automatico.sv
// Self-checking bench for jogador_automatico: displays LED sequences
// (fixed and random), then checks the replayed presses, timing and the
// error / end-of-game behaviour against an expected-press queue.
module tb_jogador_automatico;

    localparam int HOLD      = 10;
    localparam int GAP       = 10;
    localparam int QUIET     = 100;
    localparam int JOGAR_CYC = 5;

    logic       clock = 1'b0;
    logic       reset, iniciar, ganhou, perdeu, timeout;
    logic [3:0] leds;
    logic       jogar, ocupado, fim, erro_captura;
    logic [3:0] botoes, db_estado;
    logic [4:0] db_tamanho;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: the presses expected are exactly the elements shown.
    logic [3:0] exp_q [$];

    jogador_automatico #(
        .HOLD(HOLD), .GAP(GAP), .QUIET(QUIET), .JOGAR_CYC(JOGAR_CYC)
    ) dut (
        .clock(clock), .reset(reset), .iniciar(iniciar), .leds(leds),
        .ganhou(ganhou), .perdeu(perdeu), .timeout(timeout),
        .jogar(jogar), .botoes(botoes), .ocupado(ocupado), .fim(fim),
        .erro_captura(erro_captura), .db_tamanho(db_tamanho), .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic show(input logic [3:0] val, input int lit, input int dark);
        leds = val;
        repeat (lit) tick();
        leds = 4'b0000;
        repeat (dark) tick();
        exp_q.push_back(val);
    endtask

    task automatic start_game();
        int w;
        iniciar = 1'b1;
        tick();
        iniciar = 1'b0;
        w = 0;
        while (db_estado != 4'd2 && w < 20) begin
            tick();
            w++;
        end
        n_cmp++;
        if (db_estado !== 4'd2) begin
            n_bad++;
            $display("FAIL start_game: db_estado=%0d required 2", db_estado);
        end
    endtask

    // Waits for the replay and checks every press value, HOLD length and GAP length.
    task automatic check_replay(input string name, input bit noise);
        int waited, run;
        bit bad_val;
        waited = 0;
        while (db_estado != 4'd4 && waited < QUIET + 10) begin
            tick();
            waited++;
        end
        n_cmp++;
        if (waited < QUIET || waited > QUIET + 2) begin
            n_bad++;
            $display("FAIL %s first_press: waited=%0d cycles required %0d..%0d", name, waited, QUIET, QUIET + 2);
        end
        foreach (exp_q[i]) begin
            run = 0;
            bad_val = 1'b0;
            while (db_estado == 4'd4 && run < HOLD + 5) begin
                if (botoes !== exp_q[i]) bad_val = 1'b1;
                if (noise) leds = 4'($urandom_range(0, 15));
                tick();
                run++;
            end
            n_cmp++;
            if (bad_val || run != HOLD) begin
                n_bad++;
                $display("FAIL %s press[%0d]: botoes=%b len=%0d required %b len=%0d", name, i, botoes, run, exp_q[i], HOLD);
            end
            run = 0;
            bad_val = 1'b0;
            while (db_estado == 4'd5 && run < GAP + 5) begin
                if (botoes !== 4'b0000) bad_val = 1'b1;
                if (noise) leds = 4'($urandom_range(0, 15));
                tick();
                run++;
            end
            leds = 4'b0000;
            n_cmp++;
            if (bad_val || run != GAP) begin
                n_bad++;
                $display("FAIL %s gap[%0d]: botoes=%b len=%0d required 0000 len=%0d", name, i, botoes, run, GAP);
            end
        end
        n_cmp++;
        if (db_estado !== 4'd2 || db_tamanho !== 5'd0 || erro_captura !== 1'b0) begin
            n_bad++;
            $display("FAIL %s after_replay: estado=%0d tam=%0d erro=%b required 2 0 0", name, db_estado, db_tamanho, erro_captura);
        end
        exp_q.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        n_cmp++;
        if ({jogar, botoes, ocupado, fim, erro_captura, db_tamanho, db_estado} !== 16'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: jogar=%b botoes=%b ocupado=%b fim=%b erro=%b tam=%0d estado=%0d required all 0",
                     jogar, botoes, ocupado, fim, erro_captura, db_tamanho, db_estado);
        end
        reset = 1'b0;
        tick();
        n_cmp++;
        if (db_estado !== 4'd0 || ocupado !== 1'b0) begin
            n_bad++;
            $display("FAIL idle_after_reset: estado=%0d ocupado=%b required 0 0", db_estado, ocupado);
        end
    endtask

    task automatic test_start_pulse();
        int run;
        iniciar = 1'b1;
        tick();
        iniciar = 1'b0;
        run = 0;
        while (jogar === 1'b1 && run < 20) begin
            n_cmp++;
            if (db_estado !== 4'd1 || ocupado !== 1'b1) begin
                n_bad++;
                $display("FAIL pulse_state: estado=%0d ocupado=%b required 1 1", db_estado, ocupado);
            end
            tick();
            run++;
        end
        n_cmp++;
        if (run != JOGAR_CYC) begin
            n_bad++;
            $display("FAIL jogar_width: %0d cycles required %0d", run, JOGAR_CYC);
        end
        n_cmp++;
        if (db_estado !== 4'd2 || jogar !== 1'b0) begin
            n_bad++;
            $display("FAIL after_pulse: estado=%0d jogar=%b required 2 0", db_estado, jogar);
        end
    endtask

    task automatic test_ignore_iniciar();
        iniciar = 1'b1;
        tick();
        iniciar = 1'b0;
        n_cmp++;
        if (db_estado !== 4'd2 || jogar !== 1'b0) begin
            n_bad++;
            $display("FAIL ignore_iniciar: estado=%0d jogar=%b required 2 0", db_estado, jogar);
        end
    endtask

    task automatic test_single();
        show(4'b0001, 10, 0);
        check_replay("single", 1'b0);
    endtask

    task automatic test_four();
        show(4'b0001, 10, 5);
        show(4'b0010, 10, 5);
        show(4'b0100, 10, 5);
        show(4'b1000, 10, 0);
        n_cmp++;
        if (db_tamanho !== 5'd4) begin
            n_bad++;
            $display("FAIL four_size: db_tamanho=%0d required 4", db_tamanho);
        end
        check_replay("four_echo", 1'b1);
    endtask

    task automatic test_repeat();
        show(4'b0001, 8, 6);
        show(4'b0001, 8, 0);
        tick();
        n_cmp++;
        if (db_tamanho !== 5'd2) begin
            n_bad++;
            $display("FAIL repeat_size: db_tamanho=%0d required 2", db_tamanho);
        end
        check_replay("repeat", 1'b0);
    endtask

    task automatic test_random_rounds();
        int n;
        for (int r = 0; r < 4; r++) begin
            n = (r == 0) ? 16 : $urandom_range(1, 16);
            for (int k = 0; k < n; k++) begin
                show(4'b0001 << $urandom_range(0, 3), $urandom_range(1, 12),
                     (k == n - 1) ? 0 : $urandom_range(1, 20));
            end
            tick();
            n_cmp++;
            if (db_tamanho !== 5'(n)) begin
                n_bad++;
                $display("FAIL random_size[%0d]: db_tamanho=%0d required %0d", r, db_tamanho, n);
            end
            check_replay("random", r[0]);
        end
    endtask

    task automatic expect_error(input string name);
        n_cmp++;
        if (erro_captura !== 1'b1 || fim !== 1'b1 || botoes !== 4'b0000 ||
            db_estado !== 4'd15 || ocupado !== 1'b0) begin
            n_bad++;
            $display("FAIL %s: erro=%b fim=%b botoes=%b estado=%0d ocupado=%b required 1 1 0000 15 0",
                     name, erro_captura, fim, botoes, db_estado, ocupado);
        end
    endtask

    task automatic test_bad_pattern();
        logic [3:0] v;
        show(4'b0100, 5, 3);
        do v = 4'($urandom_range(1, 15)); while ($countones(v) < 2);
        leds = v;
        tick();
        leds = 4'b0000;
        expect_error("bad_pattern");
        tick();
        expect_error("bad_pattern_hold");
        exp_q.delete();
    endtask

    task automatic test_restart_clears();
        start_game();
        n_cmp++;
        if (erro_captura !== 1'b0 || fim !== 1'b0 || db_tamanho !== 5'd0) begin
            n_bad++;
            $display("FAIL restart_clear: erro=%b fim=%b tam=%0d required 0 0 0", erro_captura, fim, db_tamanho);
        end
    endtask

    task automatic test_overflow();
        for (int k = 0; k < 16; k++) show(4'b0001 << (k % 4), 4, 3);
        n_cmp++;
        if (db_tamanho !== 5'd16 || db_estado !== 4'd2) begin
            n_bad++;
            $display("FAIL overflow_full: tam=%0d estado=%0d required 16 2", db_tamanho, db_estado);
        end
        leds = 4'b0010;
        tick();
        leds = 4'b0000;
        expect_error("overflow");
        exp_q.delete();
    endtask

    task automatic wait_press(input string name);
        int w;
        w = 0;
        while (db_estado != 4'd4 && w < QUIET + 10) begin
            tick();
            w++;
        end
        n_cmp++;
        if (db_estado !== 4'd4) begin
            n_bad++;
            $display("FAIL %s wait_press: estado=%0d required 4", name, db_estado);
        end
    endtask

    task automatic test_perdeu();
        show(4'b1000, 6, 4);
        show(4'b0010, 6, 0);
        wait_press("perdeu");
        repeat (3) tick();
        n_cmp++;
        if (botoes !== 4'b1000) begin
            n_bad++;
            $display("FAIL perdeu_pressing: botoes=%b required 1000", botoes);
        end
        perdeu = 1'b1;
        tick();
        perdeu = 1'b0;
        n_cmp++;
        if (botoes !== 4'b0000 || db_estado !== 4'd15 || fim !== 1'b1 || jogar !== 1'b0 || erro_captura !== 1'b0) begin
            n_bad++;
            $display("FAIL perdeu_end: botoes=%b estado=%0d fim=%b jogar=%b erro=%b required 0000 15 1 0 0",
                     botoes, db_estado, fim, jogar, erro_captura);
        end
        iniciar = 1'b1;
        tick();
        iniciar = 1'b0;
        n_cmp++;
        if (db_estado !== 4'd1 || jogar !== 1'b1 || fim !== 1'b0) begin
            n_bad++;
            $display("FAIL perdeu_restart: estado=%0d jogar=%b fim=%b required 1 1 0", db_estado, jogar, fim);
        end
        exp_q.delete();
    endtask

    task automatic test_reset_midpress();
        int w;
        w = 0;
        while (db_estado != 4'd2 && w < 20) begin
            tick();
            w++;
        end
        show(4'b0100, 6, 0);
        wait_press("midpress");
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_cmp++;
        if (botoes !== 4'b0000 || db_estado !== 4'd0 || db_tamanho !== 5'd0 || ocupado !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_midpress: botoes=%b estado=%0d tam=%0d ocupado=%b required 0000 0 0 0",
                     botoes, db_estado, db_tamanho, ocupado);
        end
        exp_q.delete();
    endtask

    task automatic test_ganhou_timeout();
        start_game();
        show(4'b0001, 4, 2);
        timeout = 1'b1;
        tick();
        timeout = 1'b0;
        n_cmp++;
        if (db_estado !== 4'd15 || fim !== 1'b1) begin
            n_bad++;
            $display("FAIL timeout_end: estado=%0d fim=%b required 15 1", db_estado, fim);
        end
        start_game();
        ganhou = 1'b1;
        tick();
        ganhou = 1'b0;
        n_cmp++;
        if (db_estado !== 4'd15 || fim !== 1'b1 || botoes !== 4'b0000) begin
            n_bad++;
            $display("FAIL ganhou_end: estado=%0d fim=%b botoes=%b required 15 1 0000", db_estado, fim, botoes);
        end
        exp_q.delete();
    endtask

    initial begin
        reset   = 1'b1;
        iniciar = 1'b0;
        leds    = 4'b0000;
        ganhou  = 1'b0;
        perdeu  = 1'b0;
        timeout = 1'b0;

        test_reset();
        test_start_pulse();
        test_ignore_iniciar();
        test_single();
        test_four();
        test_repeat();
        test_random_rounds();
        test_bad_pattern();
        test_restart_clears();
        test_overflow();
        test_restart_clears();
        test_perdeu();
        test_reset_midpress();
        test_ganhou_timeout();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/jogador_automatico.md
JOGADOR_AUTOMATICO -- requirements
Module: jogador_automatico

Interface
REQ-001 Parameter HOLD, default 10: cycles each replayed button is held.
REQ-002 Parameter GAP, default 10: cycles of botoes=0000 after each press.
REQ-003 Parameter QUIET, default 100: consecutive dark-led cycles that mark end of a displayed sequence.
REQ-004 Parameter JOGAR_CYC, default 5: width of the jogar pulse, in cycles.
REQ-005 Ports SHALL be:
clock  in  1  sole clock, rising edge
reset  in  1  synchronous, active-high
iniciar  in  1  start request from bench or operator
leds  in  4  game LED output, one-hot while an element is shown
ganhou  in  1  game won
perdeu  in  1  game lost
timeout  in  1  game timed out
jogar  out  1  start pulse to game
botoes  out  4  button drive to game
ocupado  out  1  high in every state except INICIAL and FIM
fim  out  1  game ended or capture error
erro_captura  out  1  sticky, illegal LED pattern or overflow
db_tamanho  out  5  number of captured elements, 0..16
db_estado  out  4  state code
REQ-006 All outputs SHALL be registered.

Function
REQ-007 States and db_estado codes: INICIAL=0, PULSA_JOGAR=1, ESCUTA=2, ACESO=3, PRESSIONA=4, SOLTA=5, FIM=15.
REQ-008 INICIAL or FIM, iniciar=1 -> PULSA_JOGAR; clear erro_captura, fim, db_tamanho.
REQ-009 PULSA_JOGAR: jogar=1 for exactly JOGAR_CYC cycles, then -> ESCUTA, quiet counter=0.
REQ-010 ESCUTA, leds=0000: increment quiet counter (saturating).
REQ-010a ESCUTA, quiet counter reaches QUIET with db_tamanho>0 -> PRESSIONA, index=0.
REQ-010b ESCUTA, quiet counter reaches QUIET with db_tamanho=0 -> stay in ESCUTA.
REQ-011 ESCUTA, leds one-hot and db_tamanho<16: store leds at mem[db_tamanho], increment db_tamanho, clear quiet counter, -> ACESO.
REQ-012 ESCUTA, leds nonzero and not one-hot: set erro_captura=1 -> FIM.
REQ-012a ESCUTA, leds nonzero with db_tamanho=16: set erro_captura=1 -> FIM.
REQ-013 ACESO: stay while leds nonzero (a changed value while lit is not captured); leds=0000 -> ESCUTA with quiet counter=0.
REQ-013a Repeated equal elements SHALL be captured separately, provided the LEDs go dark between them.
REQ-014 PRESSIONA: botoes=mem[index] for HOLD cycles -> SOLTA.
REQ-015 SOLTA: botoes=0000 for GAP cycles, index+1.
REQ-015a SOLTA end, index=db_tamanho -> ESCUTA, db_tamanho=0, quiet counter=0 (the next round's display is captured fresh).
REQ-015b SOLTA end, index<db_tamanho -> PRESSIONA.
REQ-016 leds SHALL be ignored in PRESSIONA and SOLTA (game echo).
REQ-017 ganhou, perdeu or timeout high in any state other than INICIAL or FIM -> FIM on the next edge.
REQ-017a The REQ-017 end condition has priority over all other transitions except reset.
REQ-017b On entering FIM via REQ-017: botoes=0000 and jogar=0 on the same edge.
REQ-018 FIM: fim=1, botoes=0000; hold until iniciar or reset.
REQ-019 iniciar SHALL be ignored in all states except INICIAL and FIM.
REQ-020 Index and db_tamanho SHALL never exceed 16; the memory holds 16 entries of 4 bits.

Reset
REQ-021 reset=1 at a rising edge -> INICIAL. On that edge:
- jogar=0, botoes=0000, ocupado=0, fim=0, erro_captura=0
- db_tamanho=0, db_estado=0, all counters=0
REQ-022 Reset mid-press SHALL release botoes on the same edge.
REQ-022a Memory contents need not be cleared by reset.

Verification
REQ-023 Reset, then iniciar for 1 cycle -> jogar high exactly 5 cycles; db_estado 1 then 2.
REQ-024 leds shows 0001 for 10 cycles then 0000 for 100 cycles -> botoes=0001 for 10 cycles, then 0000 for 10 cycles -> back to ESCUTA with db_tamanho=0.
REQ-025 Display 0001,0010,0100,1000, each lit 10 cycles with 5 dark cycles between -> replay presses 0001,0010,0100,1000 in order, each lasting 10 cycles with a 10-cycle gap.
REQ-026 Display 0001,0001 separated by a dark gap -> db_tamanho=2; two separate 0001 presses.
REQ-027 leds=0011 in ESCUTA -> erro_captura=1, fim=1, botoes=0000.
REQ-027a A 17th lit element -> erro_captura=1, fim=1, botoes=0000.
REQ-028 perdeu pulses during PRESSIONA -> next edge: botoes=0000 and db_estado=15.
REQ-028a After REQ-028, iniciar restarts at PULSA_JOGAR.
